codeword_translator: RTL and testbench



---
 rtl/codeword_translator.sv | 187 ++++++++++++++++++
 tb/tb_codeword_translator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/codeword_translator.sv
// Backscatter codeword translator: clock/4 RF switch square wave, phase-rotated per symbol.
// Optional QUAD_PHASE_EN: 2-bit symbols with 90-degree phase steps.
module codeword_translator #(
  parameter int SYMBOL_CYCLES = 20,
  parameter int GUARD_SYMBOLS = 4,
  parameter int LEN_W         = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       phase_in,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [1:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             rf_switch,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int CW = $clog2(SYMBOL_CYCLES);
  localparam int GW = $clog2(GUARD_SYMBOLS + 1);
  localparam int SW = (LEN_W > GW) ? LEN_W : GW;
  localparam logic [CW-1:0] CLAST = CW'(SYMBOL_CYCLES - 1);
  localparam logic [SW-1:0] GLAST =
    SW'((GUARD_SYMBOLS > 0) ? GUARD_SYMBOLS - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    SHIFT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cyc_q, cyc_d;
  logic [SW-1:0]    sym_q, sym_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] acc_q, acc_d;
  logic [1:0]       buf_q, buf_d;
  logic             bvld_q, bvld_d;
  logic [1:0]       off_q, off_d;
  logic             und_q, und_d;
  logic             rf_q, rf_d;

  logic [1:0]    din_off;
  logic [1:0]    ph_sum;
  logic [SW-1:0] lenm1;
  logic          eos;
  logic          g_last;
  logic          s_last;
  logic          bnd;
  logic          xfer;

`ifdef QUAD_PHASE_EN
  assign din_off = data_in;
`else
  logic unused_d1;
  assign unused_d1 = data_in[1];
  assign din_off   = {data_in[0], 1'b0};
`endif

  assign ph_sum = phase_in + off_q;
  assign lenm1  = SW'(len_q) - SW'(1);
  assign eos    = (cyc_q == CLAST);
  assign g_last = (state_q == GUARD) && eos && (sym_q == GLAST);
  assign s_last = (state_q == SHIFT) && eos && (sym_q == lenm1);
  // The last symbol of a frame has no following symbol to load.
  assign bnd    = g_last || ((state_q == SHIFT) && eos && !s_last);

  assign busy       = (state_q == GUARD) || (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign data_ready = busy && !bvld_q && (acc_q < len_q);
  assign xfer       = data_valid && data_ready;
  assign underrun   = und_q || (bnd && !bvld_q && !xfer);
  assign rf_switch  = rf_q;

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    sym_d   = sym_q;
    len_d   = len_q;
    acc_d   = acc_q;
    buf_d   = buf_q;
    bvld_d  = bvld_q;
    off_d   = off_q;
    und_d   = und_q;
    rf_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          und_d  = 1'b0;
          acc_d  = '0;
          bvld_d = 1'b0;
          off_d  = 2'b00;
          cyc_d  = '0;
          sym_d  = '0;
          len_d  = frame_len;
          if (frame_len == '0) begin
            state_d = DONE;
          end else if (GUARD_SYMBOLS == 0) begin
            state_d = SHIFT;
          end else begin
            state_d = GUARD;
          end
        end
      end
      GUARD: begin
        rf_d  = phase_in[1];
        cyc_d = eos ? '0 : cyc_q + CW'(1);
        if (eos) begin
          sym_d = g_last ? '0 : sym_q + SW'(1);
        end
        if (g_last) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        rf_d  = ph_sum[1];
        cyc_d = eos ? '0 : cyc_q + CW'(1);
        if (eos) begin
          sym_d = sym_q + SW'(1);
        end
        if (s_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (xfer) begin
      acc_d = acc_q + LEN_W'(1);
    end
    if (bnd) begin
      if (bvld_q) begin
        off_d  = buf_q;
        bvld_d = 1'b0;
      end else if (xfer) begin
        off_d = din_off;
      end else begin
        // Starved symbol goes out unrotated but still uses its slot.
        off_d = 2'b00;
        und_d = 1'b1;
        if (acc_q != len_q) begin
          acc_d = acc_q + LEN_W'(1);
        end
      end
    end else if (xfer) begin
      buf_d  = din_off;
      bvld_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      sym_q   <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      buf_q   <= 2'b00;
      bvld_q  <= 1'b0;
      off_q   <= 2'b00;
      und_q   <= 1'b0;
      rf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      sym_q   <= sym_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      buf_q   <= buf_d;
      bvld_q  <= bvld_d;
      off_q   <= off_d;
      und_q   <= und_d;
      rf_q    <= rf_d;
    end
  end

endmodule

// File: tb/tb_codeword_translator.sv
// Directed, table-driven bench for codeword_translator.
// Frame records drive a cycle-exact model of busy/done/underrun/rf_switch.
module tb_codeword_translator;

  localparam int S  = 20;
  localparam int G  = 4;
  localparam int LW = 12;
  localparam int GS = G * S;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    phase_in;
  logic          start;
  logic [LW-1:0] frame_len;
  logic [1:0]    data_in;
  logic          data_valid;
  logic          data_ready;
  logic          rf_switch;
  logic          busy;
  logic          done;
  logic          underrun;

  int checks = 0;
  int errors = 0;

  codeword_translator #(
    .SYMBOL_CYCLES(S),
    .GUARD_SYMBOLS(G),
    .LEN_W(LW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .phase_in(phase_in),
    .start(start),
    .frame_len(frame_len),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .rf_switch(rf_switch),
    .busy(busy),
    .done(done),
    .underrun(underrun)
  );

  always #5 clock = ~clock;

  // mode: 0 no data, 1 prompt, 2 valid held high, 3 first data on boundary
  typedef struct {
    int              len;
    logic [3:0][1:0] d;
    int              mode;
    bit              poke;
  } vec_t;

  vec_t tv[8];

  function automatic vec_t mk(input int len, input logic [1:0] d0,
                              input logic [1:0] d1, input logic [1:0] d2,
                              input int mode, input bit poke);
    vec_t v;
    v.len  = len;
    v.d    = '0;
    v.d[0] = d0;
    v.d[1] = d1;
    v.d[2] = d2;
    v.mode = mode;
    v.poke = poke;
    return v;
  endfunction

  function automatic logic [1:0] offval(input logic [1:0] d);
`ifdef QUAD_PHASE_EN
    return d;
`else
    return (d << 1) & 2'b10;
`endif
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    phase_in = phase_in + 2'd1;
  endtask

  task automatic run_frame(input vec_t v);
    int         dc;
    int         nx;
    int         k;
    logic       rf_nxt;
    logic [1:0] off;
    logic [1:0] sm;
    dc     = (v.len == 0) ? 1 : 1 + GS + v.len * S;
    nx     = 0;
    rf_nxt = 1'b0;
    for (int c = 0; c <= dc + 1; c++) begin
      start     = (c == 0) || (v.poke && c == 90);
      frame_len = (c == 0) ? LW'(v.len) : '0;
      case (v.mode)
        0:       data_valid = 1'b0;
        1:       data_valid = (nx < v.len);
        2:       data_valid = 1'b1;
        default: data_valid = (c >= GS) && (nx < v.len);
      endcase
      data_in = v.d[(nx < v.len) ? nx : 0];
      @(negedge clock);
      chk("rf_switch", rf_switch, rf_nxt);
      chk("busy", busy, v.len != 0 && c >= 1 && c < dc);
      chk("done", done, c == dc);
      if (v.len != 0 && c >= 1)
        chk("underrun", underrun, v.mode == 0 && c >= GS);
      if (v.len == 0 || (v.mode == 2 && nx == v.len))
        chk("data_ready", data_ready, 1'b0);
      if (data_valid && data_ready) nx++;
      if (v.len != 0 && c >= 1 && c <= GS) begin
        rf_nxt = phase_in[1];
      end else if (v.len != 0 && c > GS && c < dc) begin
        k      = (c - GS - 1) / S;
        off    = (v.mode == 0) ? 2'b00 : offval(v.d[k]);
        sm     = phase_in + off;
        rf_nxt = sm[1];
      end else begin
        rf_nxt = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    data_valid = 1'b0;
    if (v.mode != 0) chk_int("transfers", nx, v.len);
  endtask

  initial begin
    tv[0] = mk(3, 2'd1, 2'd0, 2'd1, 1, 1'b0);
    tv[1] = mk(0, 2'd0, 2'd0, 2'd0, 1, 1'b0);
    tv[2] = mk(2, 2'd0, 2'd0, 2'd0, 0, 1'b0);
    tv[3] = mk(2, 2'd1, 2'd1, 2'd0, 2, 1'b0);
    tv[4] = mk(2, 2'd0, 2'd1, 2'd0, 1, 1'b1);
    tv[5] = mk(2, 2'd1, 2'd0, 2'd0, 3, 1'b0);
    tv[6] = mk(3, 2'b10, 2'b11, 2'b01, 1, 1'b0);
    tv[7] = mk(1, 2'd1, 2'd0, 2'd0, 1, 1'b0);

    reset      = 1'b1;
    phase_in   = 2'd0;
    start      = 1'b0;
    frame_len  = '0;
    data_in    = 2'd0;
    data_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    chk("rst_rf", rf_switch, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    chk("rst_ready", data_ready, 1'b0);
    tick();

    for (int i = 0; i < 8; i++) run_frame(tv[i]);

    // Reset in mid-SHIFT with underrun already flagged.
    for (int c = 0; c <= 95; c++) begin
      start      = (c == 0);
      frame_len  = LW'(2);
      data_valid = 1'b0;
      @(negedge clock);
      if (c == 95) begin
        chk("mid_busy", busy, 1'b1);
        chk("mid_underrun", underrun, 1'b1);
      end
      tick();
    end
    start = 1'b0;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("rst_no_done", done, 1'b0);
      tick();
    end
    reset = 1'b0;
    @(negedge clock);
    chk("rst2_rf", rf_switch, 1'b0);
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_ready", data_ready, 1'b0);
    chk("rst2_underrun", underrun, 1'b0);
    chk("rst2_done", done, 1'b0);
    tick();
    repeat (4) begin
      @(negedge clock);
      chk("idle_done", done, 1'b0);
      chk("idle_busy", busy, 1'b0);
      tick();
    end
    run_frame(tv[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
